// File: rtl/axi4_lite_slave_mem_pkg.sv
// Shared widths, response codes and FSM state types for the AXI4-Lite memory responder.
package axi4_lite_slave_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam int RESP_W = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_WAIT,
        RD_RESP
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_COMMIT,
        WR_RESP
    } wr_state_t;

    function automatic logic [RESP_W-1:0] resp_for(input logic hit);
        return hit ? RESP_OKAY : RESP_DECERR;
    endfunction

endpackage

// File: rtl/axi4_lite_slave_mem_sram_bank.sv
// Word-addressed storage split into byte lanes: asynchronous read, byte-strobed synchronous write.
module axi4_lite_sram_bank
    import axi4_lite_slave_mem_pkg::*;
#(
    parameter int P_DEPTH = 1024,
    parameter int P_IDX_W = $clog2(P_DEPTH)
) (
    input  logic               iClock,
    input  logic               i_we,
    input  logic [P_IDX_W-1:0] i_waddr,
    input  logic [DATA_W-1:0]  i_wdata,
    input  logic [STRB_W-1:0]  i_wstrb,
    input  logic [P_IDX_W-1:0] i_raddr,
    output logic [DATA_W-1:0]  o_rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_lane
            // One array per byte lane so each lane has a single writer.
            logic [7:0] r_mem [P_DEPTH];

            always_ff @(posedge iClock) begin
                if (i_we && i_wstrb[gi]) begin
                    r_mem[i_waddr] <= i_wdata[gi*8 +: 8];
                end
            end

            assign o_rdata[gi*8 +: 8] = r_mem[i_raddr];
        end
    endgenerate

endmodule

// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite responder over on-chip memory; independent read and write FSMs.
// Define AXI4LITE_SLV_LATENCY_EN to insert P_RD_LATENCY wait cycles before each read response.
module axi4_lite_slave_mem
    import axi4_lite_slave_mem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] P_BASE_ADDR  = 32'h8000_0000,
    parameter int                P_MEM_DEPTH  = 1024,
    parameter int                P_RD_LATENCY = 2
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              pAXI4_ar_valid,
    output logic              pAXI4_ar_ready,
    input  logic [ADDR_W-1:0] pAXI4_ar_bits_addr,
    output logic              pAXI4_r_valid,
    input  logic              pAXI4_r_ready,
    output logic [DATA_W-1:0] pAXI4_r_bits_data,
    output logic [RESP_W-1:0] pAXI4_r_bits_resp,
    input  logic              pAXI4_aw_valid,
    output logic              pAXI4_aw_ready,
    input  logic [ADDR_W-1:0] pAXI4_aw_bits_addr,
    input  logic              pAXI4_w_valid,
    output logic              pAXI4_w_ready,
    input  logic [DATA_W-1:0] pAXI4_w_bits_data,
    input  logic [STRB_W-1:0] pAXI4_w_bits_strb,
    output logic              pAXI4_b_valid,
    input  logic              pAXI4_b_ready,
    output logic [RESP_W-1:0] pAXI4_b_bits_resp
);

`ifdef AXI4LITE_SLV_LATENCY_EN
    localparam int LP_RD_WAIT = P_RD_LATENCY;
`else
    localparam int LP_RD_WAIT = 0;
`endif
    localparam int              LP_CNT_W = (P_RD_LATENCY > 1) ? $clog2(P_RD_LATENCY) : 1;
    localparam int              LP_IDX_W = $clog2(P_MEM_DEPTH);
    localparam logic [ADDR_W:0] LP_SPAN  = (ADDR_W + 1)'(4 * P_MEM_DEPTH);

    // Offset computed one bit wider so the upper bound never wraps.
    function automatic logic addr_hit(input logic [ADDR_W-1:0] addr);
        return (addr >= P_BASE_ADDR) && (({1'b0, addr} - {1'b0, P_BASE_ADDR}) < LP_SPAN);
    endfunction

    function automatic logic [LP_IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
        return LP_IDX_W'((addr - P_BASE_ADDR) >> 2);
    endfunction

    rd_state_t           r_rd_state;
    logic                r_ar_ready;
    logic                r_r_valid;
    logic [DATA_W-1:0]   r_r_data;
    logic [RESP_W-1:0]   r_r_resp;
    logic [LP_CNT_W-1:0] r_rd_cnt;

    wr_state_t           r_wr_state;
    logic                r_aw_ready;
    logic                r_w_ready;
    logic                r_aw_got;
    logic                r_w_got;
    logic [ADDR_W-1:0]   r_aw_addr;
    logic [DATA_W-1:0]   r_w_data;
    logic [STRB_W-1:0]   r_w_strb;
    logic                r_b_valid;
    logic [RESP_W-1:0]   r_b_resp;

    logic                w_ar_hs;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_ar_hit;
    logic                w_wr_hit;
    logic                w_we;
    logic [DATA_W-1:0]   w_mem_rdata;

    assign w_ar_hs  = pAXI4_ar_valid && r_ar_ready;
    assign w_aw_hs  = pAXI4_aw_valid && r_aw_ready;
    assign w_w_hs   = pAXI4_w_valid && r_w_ready;
    assign w_ar_hit = addr_hit(pAXI4_ar_bits_addr);
    assign w_wr_hit = addr_hit(r_aw_addr);
    // Reset in the commit cycle suppresses the write entirely.
    assign w_we     = (r_wr_state == WR_COMMIT) && w_wr_hit && !iReset;

    axi4_lite_sram_bank #(
        .P_DEPTH (P_MEM_DEPTH),
        .P_IDX_W (LP_IDX_W)
    ) u_bank (
        .iClock  (iClock),
        .i_we    (w_we),
        .i_waddr (addr_idx(r_aw_addr)),
        .i_wdata (r_w_data),
        .i_wstrb (r_w_strb),
        .i_raddr (addr_idx(pAXI4_ar_bits_addr)),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_rd_state <= RD_IDLE;
            r_ar_ready <= 1'b0;
            r_r_valid  <= 1'b0;
            r_r_data   <= '0;
            r_r_resp   <= RESP_OKAY;
            r_rd_cnt   <= '0;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    r_ar_ready <= 1'b1;
                    if (w_ar_hs) begin
                        // Memory sampled here, so a same-cycle commit is not observed.
                        r_ar_ready <= 1'b0;
                        r_r_data   <= w_ar_hit ? w_mem_rdata : '0;
                        r_r_resp   <= resp_for(w_ar_hit);
                        if (LP_RD_WAIT == 0) begin
                            r_r_valid  <= 1'b1;
                            r_rd_state <= RD_RESP;
                        end else begin
                            r_rd_cnt   <= LP_CNT_W'(LP_RD_WAIT - 1);
                            r_rd_state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (r_rd_cnt == '0) begin
                        r_r_valid  <= 1'b1;
                        r_rd_state <= RD_RESP;
                    end else begin
                        r_rd_cnt <= r_rd_cnt - 1'b1;
                    end
                end
                RD_RESP: begin
                    if (pAXI4_r_ready) begin
                        r_r_valid  <= 1'b0;
                        r_ar_ready <= 1'b1;
                        r_rd_state <= RD_IDLE;
                    end
                end
                default: r_rd_state <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_wr_state <= WR_IDLE;
            r_aw_ready <= 1'b0;
            r_w_ready  <= 1'b0;
            r_aw_got   <= 1'b0;
            r_w_got    <= 1'b0;
            r_b_valid  <= 1'b0;
            r_b_resp   <= RESP_OKAY;
        end else begin
            case (r_wr_state)
                WR_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_addr <= pAXI4_aw_bits_addr;
                        r_aw_got  <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_data <= pAXI4_w_bits_data;
                        r_w_strb <= pAXI4_w_bits_strb;
                        r_w_got  <= 1'b1;
                    end
                    if ((r_aw_got || w_aw_hs) && (r_w_got || w_w_hs)) begin
                        r_aw_ready <= 1'b0;
                        r_w_ready  <= 1'b0;
                        r_aw_got   <= 1'b0;
                        r_w_got    <= 1'b0;
                        r_wr_state <= WR_COMMIT;
                    end else begin
                        r_aw_ready <= !(r_aw_got || w_aw_hs);
                        r_w_ready  <= !(r_w_got || w_w_hs);
                    end
                end
                WR_COMMIT: begin
                    r_b_valid  <= 1'b1;
                    r_b_resp   <= resp_for(w_wr_hit);
                    r_wr_state <= WR_RESP;
                end
                WR_RESP: begin
                    if (pAXI4_b_ready) begin
                        r_b_valid  <= 1'b0;
                        r_aw_ready <= 1'b1;
                        r_w_ready  <= 1'b1;
                        r_wr_state <= WR_IDLE;
                    end
                end
                default: r_wr_state <= WR_IDLE;
            endcase
        end
    end

    assign pAXI4_ar_ready    = r_ar_ready;
    assign pAXI4_r_valid     = r_r_valid;
    assign pAXI4_r_bits_data = r_r_data;
    assign pAXI4_r_bits_resp = r_r_resp;
    assign pAXI4_aw_ready    = r_aw_ready;
    assign pAXI4_w_ready     = r_w_ready;
    assign pAXI4_b_valid     = r_b_valid;
    assign pAXI4_b_bits_resp = r_b_resp;

endmodule
